// File: rtl/fp_wb_pkg.sv
// Shared types and the round-robin helper for the FP writeback collector.
// The entry struct fixes the rd/data widths, so the top keeps ADDR_W/DATA_W at these values.
package fp_wb_pkg;

    localparam int FFLAGS_W     = 5;
    localparam int ENTRY_ADDR_W = 5;
    localparam int ENTRY_DATA_W = 32;
    localparam int MAX_UNITS    = 8;
    localparam int RR_IDX_W     = 3;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] rd;
        logic [ENTRY_DATA_W-1:0] data;
        logic [FFLAGS_W-1:0]     fflags;
    } fp_wb_entry_t;

    // The search starts just after the last grant; with no requester the pointer is returned unchanged.
    function automatic logic [RR_IDX_W-1:0] rr_next(input logic [MAX_UNITS-1:0] req,
                                                    input logic [RR_IDX_W-1:0]  ptr,
                                                    input int                   n);
        logic [RR_IDX_W-1:0] pick;
        logic                found;
        logic [31:0]         idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= MAX_UNITS; k++) begin
            idx = (32'(ptr) + 32'(k)) % 32'(n);
            if (!found && (k <= n) && req[idx[RR_IDX_W-1:0]]) begin
                pick  = idx[RR_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// Small synchronous FIFO holding completed results for one FP execution unit.
module fp_wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    // Storage needs no reset: only the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP writeback collector: per-unit FIFOs arbitrated round-robin into one registered writeback port.
// Define FP_WB_FFLAGS_EN to carry exception flags through the FIFOs onto wb_fflags.
module fp_wb_arbiter
    import fp_wb_pkg::*;
#(
    parameter int NUM_UNITS  = 3,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_UNITS-1:0]          unit_valid,
    output logic [NUM_UNITS-1:0]          unit_ready,
    input  logic [NUM_UNITS*ADDR_W-1:0]   unit_rd,
    input  logic [NUM_UNITS*DATA_W-1:0]   unit_data,
    input  logic [NUM_UNITS*5-1:0]        unit_fflags,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [ADDR_W-1:0]             wb_rd,
    output logic [DATA_W-1:0]             wb_data,
    output logic [4:0]                    wb_fflags,
    output logic [$clog2(NUM_UNITS)-1:0]  wb_unit
);

    localparam int UNIT_W = $clog2(NUM_UNITS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
`ifdef FP_WB_FFLAGS_EN
    localparam int ENTRY_W = ADDR_W + DATA_W + FFLAGS_W;
`else
    localparam int ENTRY_W = ADDR_W + DATA_W;
    logic unused_fflags;
    assign unused_fflags = ^unit_fflags;
`endif

    fp_wb_entry_t          head [NUM_UNITS];
    logic [NUM_UNITS-1:0]  push;
    logic [NUM_UNITS-1:0]  pop;
    logic [NUM_UNITS-1:0]  fifo_empty;
    logic [NUM_UNITS-1:0]  full_unused;
    logic [NUM_UNITS-1:0]  req;
    logic [UNIT_W-1:0]     rr_ptr;
    logic [UNIT_W-1:0]     grant;
    logic                  load_en;
    logic                  load;

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
        logic [ENTRY_W-1:0] wdata;
        logic [ENTRY_W-1:0] rdata;
        logic [CNT_W-1:0]   count;

`ifdef FP_WB_FFLAGS_EN
        assign wdata   = {unit_rd[i*ADDR_W +: ADDR_W], unit_data[i*DATA_W +: DATA_W],
                          unit_fflags[i*FFLAGS_W +: FFLAGS_W]};
        assign head[i] = rdata;
`else
        assign wdata   = {unit_rd[i*ADDR_W +: ADDR_W], unit_data[i*DATA_W +: DATA_W]};
        assign head[i] = {rdata, {FFLAGS_W{1'b0}}};
`endif

        // Ready comes from the registered count alone so producers never see a wb_ready path.
        assign unit_ready[i] = (count < CNT_W'(FIFO_DEPTH));
        assign push[i]       = unit_valid[i] && unit_ready[i];
        assign pop[i]        = load && (grant == UNIT_W'(i));

        fp_wb_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (push[i]),
            .pop     (pop[i]),
            .wdata   (wdata),
            .rdata   (rdata),
            .full    (full_unused[i]),
            .empty   (fifo_empty[i]),
            .count   (count)
        );
    end

    assign req     = ~fifo_empty;
    assign load_en = !wb_valid || wb_ready;
    assign load    = load_en && (|req);
    assign grant   = UNIT_W'(rr_next(MAX_UNITS'(req), RR_IDX_W'(rr_ptr), NUM_UNITS));

    // Writeback register: it only changes when the slot is free or being consumed, so a stalled result holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            wb_fflags <= '0;
            wb_unit   <= '0;
            rr_ptr    <= UNIT_W'(NUM_UNITS - 1);
        end else if (load_en) begin
            wb_valid <= |req;
            if (|req) begin
                wb_rd     <= head[grant].rd;
                wb_data   <= head[grant].data;
                wb_fflags <= head[grant].fflags;
                wb_unit   <= grant;
                rr_ptr    <= grant;
            end
        end
    end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed self-checking bench for fp_wb_arbiter (3 units, depth-2 FIFOs).
module tb_fp_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  unit_valid;
    logic [2:0]  unit_ready;
    logic [14:0] unit_rd;
    logic [95:0] unit_data;
    logic [14:0] unit_fflags;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  wb_fflags;
    logic [1:0]  wb_unit;

    int checks = 0;
    int errors = 0;

`ifdef FP_WB_FFLAGS_EN
    localparam logic [4:0] FF_EXP = 5'b00001;
`else
    localparam logic [4:0] FF_EXP = 5'b00000;
`endif

    always #5 clk = ~clk;

    fp_wb_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .unit_valid  (unit_valid),
        .unit_ready  (unit_ready),
        .unit_rd     (unit_rd),
        .unit_data   (unit_data),
        .unit_fflags (unit_fflags),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_fflags   (wb_fflags),
        .wb_unit     (wb_unit)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkWb(input string tag, input logic [4:0] rd, input logic [1:0] unit, input logic [31:0] data);
        checkOutput({tag, ".valid"}, 64'(wb_valid), 64'd1);
        checkOutput({tag, ".rd"}, 64'(wb_rd), 64'(rd));
        checkOutput({tag, ".unit"}, 64'(wb_unit), 64'(unit));
        checkOutput({tag, ".data"}, 64'(wb_data), 64'(data));
        checkOutput({tag, ".fflags"}, 64'(wb_fflags), 64'(FF_EXP));
    endtask

    task automatic applyStimulus(input logic [2:0] valid, input logic [14:0] rd,
                                 input logic [95:0] data, input logic ready);
        unit_valid = valid;
        unit_rd    = rd;
        unit_data  = data;
        wb_ready   = ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [1:0]  exp_unit [6];
        logic [4:0]  exp_rd   [6];
        logic [31:0] exp_data [6];
        exp_unit = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        exp_rd   = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
        exp_data = '{32'hA0, 32'hB0, 32'hC0, 32'hA1, 32'hB1, 32'hC1};

        // Reset with all producers asserting valid: nothing may be captured.
        unit_fflags = {3{5'b00001}};
        reset_n = 1'b0;
        applyStimulus(3'b111, {3{5'd7}}, {3{32'hDEADBEEF}}, 1'b1);
        tick();
        tick();
        checkOutput("reset.ready", 64'(unit_ready), 64'h7);
        checkOutput("reset.valid", 64'(wb_valid), 64'd0);
        checkOutput("reset.rd", 64'(wb_rd), 64'd0);
        checkOutput("reset.unit", 64'(wb_unit), 64'd0);
        reset_n = 1'b1;
        applyStimulus(3'b000, '0, '0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("post_reset.valid", 64'(wb_valid), 64'd0);
        end

        // Fairness: two results per unit, granted 0,1,2,0,1,2.
        applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC0, 32'hB0, 32'hA0}, 1'b1);
        tick();
        checkOutput("fair.latency", 64'(wb_valid), 64'd0);
        applyStimulus(3'b111, {5'd6, 5'd5, 5'd4}, {32'hC1, 32'hB1, 32'hA1}, 1'b1);
        tick();
        applyStimulus(3'b000, '0, '0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            checkWb("fair", exp_rd[k], exp_unit[k], exp_data[k]);
            tick();
        end
        checkOutput("fair.drain", 64'(wb_valid), 64'd0);

        // Single unit: one writeback, one cycle after the push.
        applyStimulus(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'h3F800000, 32'h0}, 1'b1);
        tick();
        applyStimulus(3'b000, '0, '0, 1'b1);
        checkOutput("single.latency", 64'(wb_valid), 64'd0);
        tick();
        checkWb("single", 5'd5, 2'd1, 32'h3F800000);
        tick();
        checkOutput("single.once", 64'(wb_valid), 64'd0);
        tick();
        checkOutput("single.idle", 64'(wb_valid), 64'd0);

        // Backpressure on unit 0: held output plus a full FIFO drops unit_ready[0].
        applyStimulus(3'b001, {10'd0, 5'd10}, {64'd0, 32'hA10}, 1'b0);
        tick();
        checkOutput("bp.e1.valid", 64'(wb_valid), 64'd0);
        applyStimulus(3'b001, {10'd0, 5'd11}, {64'd0, 32'hA11}, 1'b0);
        tick();
        checkWb("bp.e2", 5'd10, 2'd0, 32'hA10);
        checkOutput("bp.e2.ready", 64'(unit_ready), 64'h7);
        applyStimulus(3'b001, {10'd0, 5'd12}, {64'd0, 32'hA12}, 1'b0);
        tick();
        checkOutput("bp.e3.ready", 64'(unit_ready), 64'h6);
        checkWb("bp.e3", 5'd10, 2'd0, 32'hA10);
        applyStimulus(3'b000, '0, '0, 1'b0);
        tick();
        checkWb("bp.e4", 5'd10, 2'd0, 32'hA10);
        tick();
        checkWb("bp.e5", 5'd10, 2'd0, 32'hA10);
        checkOutput("bp.e5.ready", 64'(unit_ready), 64'h6);
        applyStimulus(3'b000, '0, '0, 1'b1);
        tick();
        checkWb("bp.e6", 5'd11, 2'd0, 32'hA11);
        checkOutput("bp.e6.ready", 64'(unit_ready), 64'h7);
        tick();
        checkWb("bp.e7", 5'd12, 2'd0, 32'hA12);
        tick();
        checkOutput("bp.drain", 64'(wb_valid), 64'd0);

        // Unit 2: fill to full, then push and pop in the same edge.
        applyStimulus(3'b100, {5'd20, 10'd0}, {32'hD20, 64'd0}, 1'b0);
        tick();
        checkOutput("pp.e1.valid", 64'(wb_valid), 64'd0);
        applyStimulus(3'b100, {5'd21, 10'd0}, {32'hD21, 64'd0}, 1'b0);
        tick();
        checkWb("pp.e2", 5'd20, 2'd2, 32'hD20);
        applyStimulus(3'b100, {5'd22, 10'd0}, {32'hD22, 64'd0}, 1'b0);
        tick();
        checkOutput("pp.full.ready", 64'(unit_ready), 64'h3);
        checkWb("pp.e3", 5'd20, 2'd2, 32'hD20);
        applyStimulus(3'b100, {5'd23, 10'd0}, {32'hD23, 64'd0}, 1'b1);
        tick();
        checkWb("pp.e4", 5'd21, 2'd2, 32'hD21);
        checkOutput("pp.e4.ready", 64'(unit_ready), 64'h7);
        tick();
        checkWb("pp.e5", 5'd22, 2'd2, 32'hD22);
        checkOutput("pp.e5.ready", 64'(unit_ready), 64'h7);
        applyStimulus(3'b000, '0, '0, 1'b1);
        tick();
        checkWb("pp.e6", 5'd23, 2'd2, 32'hD23);
        tick();
        checkOutput("pp.drain", 64'(wb_valid), 64'd0);

        // Mid-operation reset with four results buffered (one in the output register).
        applyStimulus(3'b011, {5'd0, 5'd2, 5'd1}, {32'h0, 32'hB2, 32'hA1}, 1'b0);
        tick();
        applyStimulus(3'b011, {5'd0, 5'd4, 5'd3}, {32'h0, 32'hB4, 32'hA3}, 1'b0);
        tick();
        applyStimulus(3'b000, '0, '0, 1'b0);
        checkWb("mid.before", 5'd1, 2'd0, 32'hA1);
        checkOutput("mid.before.ready", 64'(unit_ready), 64'h5);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid.async.valid", 64'(wb_valid), 64'd0);
        checkOutput("mid.async.rd", 64'(wb_rd), 64'd0);
        checkOutput("mid.async.ready", 64'(unit_ready), 64'h7);
        tick();
        tick();
        reset_n = 1'b1;
        wb_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("mid.no_stale", 64'(wb_valid), 64'd0);
        end

        // Recovery after reset: a fresh push flows through normally.
        applyStimulus(3'b010, {5'd0, 5'd9, 5'd0}, {32'h0, 32'h40000000, 32'h0}, 1'b1);
        tick();
        applyStimulus(3'b000, '0, '0, 1'b1);
        tick();
        checkWb("recover", 5'd9, 2'd1, 32'h40000000);
        tick();
        checkOutput("recover.drain", 64'(wb_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
